matrix_seq_unit: RTL and testbench



---
 rtl/matrix_pkg.sv | 37 +++
 rtl/matrix_mac.sv | 42 ++++
 rtl/matrix_seq_unit.sv | 137 +++++++++++++
 tb/tb_matrix_seq_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the time-multiplexed 2x2 matrix unit.
// Holds the FSM state enum, default widths, frame geometry and operand slot encoding.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int DW_DEF      = 8;
    localparam int RW_DEF      = 16;
    localparam int FRAME_BYTES = 8;
    localparam int RESULTS     = 4;
    localparam int N_ELEM      = 4;
    localparam int N_MAT       = 8;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    // Operand storage slots, in arrival order within a frame.
    localparam idx_t IDX_A11 = 3'd0;
    localparam idx_t IDX_A12 = 3'd1;
    localparam idx_t IDX_A21 = 3'd2;
    localparam idx_t IDX_A22 = 3'd3;
    localparam idx_t IDX_B11 = 3'd4;
    localparam idx_t IDX_B12 = 3'd5;
    localparam idx_t IDX_B21 = 3'd6;
    localparam idx_t IDX_B22 = 3'd7;

    typedef struct packed {
        idx_t a;
        idx_t b;
    } sel_t;

endpackage

// File: rtl/matrix_mac.sv
// Single shared DW x DW multiplier feeding one RW-bit accumulator.
// Build option: define MATRIX_SAT_EN to saturate the accumulate path instead of wrapping.
module matrix_mac #(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          add,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] sum
);

    logic [RW-1:0] acc;
    logic [RW-1:0] prod;
    logic [RW-1:0] acc_sum;

    assign prod = RW'(a) * RW'(b);

`ifdef MATRIX_SAT_EN
    logic [RW:0] wide;
    assign wide    = {1'b0, acc} + {1'b0, prod};
    assign acc_sum = wide[RW] ? '1 : wide[RW-1:0];
`else
    assign acc_sum = acc + prod;
`endif

    // A lone product never overflows, so only the accumulate path sees saturation.
    assign sum = add ? acc_sum : prod;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matrix_seq_unit.sv
// Sequential 2x2 element-wise / matrix product unit with byte-stream input and word-stream output.
// Build option: MATRIX_SAT_EN (handled in matrix_mac) saturates matrix-product sums.
module matrix_seq_unit
    import matrix_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    state_e        state;
    state_e        state_nxt;
    logic [2:0]    count;
    logic          op_q;
    logic [2:0]    step;
    logic [1:0]    out_idx;
    logic [DW-1:0] opnd [FRAME_BYTES];
    logic [RW-1:0] res  [RESULTS];

    logic          in_fire;
    logic          out_fire;
    logic          calc_last;
    sel_t          sel;
    logic [1:0]    res_idx;
    logic          res_wr;
    logic          mac_add;
    logic [RW-1:0] mac_sum;

    assign in_ready  = !rst && (state == IDLE || state == LOAD);
    assign out_valid = !rst && (state == DRAIN);
    assign out_last  = out_valid && (out_idx == 2'(RESULTS - 1));
    assign out_data  = out_valid ? res[out_idx] : '0;
    assign busy      = !rst && (state != IDLE);

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign calc_last = op_q ? (step == 3'(N_MAT - 1)) : (step == 3'(N_ELEM - 1));

    // Product-index table: matrix mode pairs consecutive steps into one result,
    // element-wise mode produces one finished result per step.
    always_comb begin
        sel     = '0;
        res_idx = '0;
        res_wr  = 1'b0;
        mac_add = 1'b0;
        if (op_q) begin
            case (step)
                3'd0:    sel = '{a: IDX_A11, b: IDX_B11};
                3'd1:    sel = '{a: IDX_A12, b: IDX_B21};
                3'd2:    sel = '{a: IDX_A11, b: IDX_B12};
                3'd3:    sel = '{a: IDX_A12, b: IDX_B22};
                3'd4:    sel = '{a: IDX_A21, b: IDX_B11};
                3'd5:    sel = '{a: IDX_A22, b: IDX_B21};
                3'd6:    sel = '{a: IDX_A21, b: IDX_B12};
                default: sel = '{a: IDX_A22, b: IDX_B22};
            endcase
            res_idx = step[2:1];
            mac_add = step[0];
            res_wr  = step[0];
        end else begin
            sel.a   = step;
            sel.b   = IDX_B11 | step;
            res_idx = step[1:0];
            res_wr  = 1'b1;
        end
    end

    matrix_mac #(
        .DW (DW),
        .RW (RW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .en  (state == CALC),
        .add (mac_add),
        .a   (opnd[sel.a]),
        .b   (opnd[sel.b]),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = LOAD;
            LOAD:    if (in_fire && count == 3'(FRAME_BYTES - 1)) state_nxt = CALC;
            CALC:    if (calc_last) state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_idx == 2'(RESULTS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // count and out_idx wrap back to zero on the final beat, so they are ready for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            op_q    <= 1'b0;
            step    <= '0;
            out_idx <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) opnd[i] <= '0;
            for (int i = 0; i < RESULTS; i++) res[i] <= '0;
        end else begin
            if (in_fire) begin
                opnd[count] <= in_data;
                count       <= count + 3'd1;
                if (state == IDLE) op_q <= in_op;
            end
            if (state == CALC) begin
                step <= calc_last ? 3'd0 : step + 3'd1;
                if (res_wr) res[res_idx] <= mac_sum;
            end
            if (out_fire) begin
                out_idx <= out_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_seq_unit.sv
// Randomized scoreboard bench for matrix_seq_unit; the reference model works on whole matrices.
`timescale 1ns/1ps
module tb_matrix_seq_unit;

    localparam int DW = 8;
    localparam int RW = 16;

    typedef logic [7:0] frame_t [8];
    typedef struct {
        logic [RW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_op = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          busy;

    exp_t exp_q[$];
    int   lat_edge_q[$];
    int   lat_n_q[$];
    int   ecount = 0;
    int   calc_from = 1;
    int   calc_to = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stall_mode = 0;
    int   gap_pct = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    matrix_seq_unit #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    endtask

    // Reference: 2x2 matrices as plain integers, reduced to RW bits at the end.
    function automatic void pushExpected(input bit op, input frame_t m);
        int a11, a12, a21, a22, b11, b12, b21, b22;
        int r [4];
        a11 = m[0]; a12 = m[1]; a21 = m[2]; a22 = m[3];
        b11 = m[4]; b12 = m[5]; b21 = m[6]; b22 = m[7];
        if (op) r = '{a11*b11 + a12*b21, a11*b12 + a12*b22, a21*b11 + a22*b21, a21*b12 + a22*b22};
        else    r = '{a11*b11, a12*b12, a21*b21, a22*b22};
        for (int i = 0; i < 4; i++) begin
`ifdef MATRIX_SAT_EN
            if (r[i] > (1 << RW) - 1) r[i] = (1 << RW) - 1;
`else
            r[i] = r[i] % (1 << RW);
`endif
            exp_q.push_back('{data: RW'(r[i]), last: (i == 3)});
        end
    endfunction

    task automatic applyStimulus(input bit op, input frame_t m, input int nbytes);
        int t;
        bit rdy;
        int n;
        n = op ? 8 : 4;
        for (int i = 0; i < nbytes; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                in_op    = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = m[i];
            in_op    = (i == 0) ? op : 1'($urandom);
            t   = 0;
            rdy = 1'b0;
            while (!rdy && t < 500) begin
                @(negedge clk);
                rdy = in_ready;
                if (rdy && i == 7) begin
                    pushExpected(op, m);
                    lat_edge_q.push_back(ecount + 1);
                    lat_n_q.push_back(n);
                    calc_from = ecount + 1;
                    calc_to   = ecount + n;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!rdy) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Consumer: always ready, random ready, or three idle cycles before taking each word.
    int hold = 0;
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom);
            default: begin
                if (!out_valid) begin
                    hold = 0;
                    out_ready = 1'b0;
                end else if (hold >= 3) begin
                    hold = 0;
                    out_ready = 1'b1;
                end else begin
                    hold++;
                    out_ready = 1'b0;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on every accepted word and watches handshake rules.
    logic          prev_valid = 1'b0;
    logic          prev_hold = 1'b0;
    logic [RW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    int            word_idx = 0;
    always @(negedge clk) begin
        exp_t x;
        int   e;
        int   n;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
            word_idx   = 0;
        end else begin
            if (ecount >= calc_from && ecount <= calc_to) begin
                checkOutput("in_ready_calc", 32'(in_ready), 32'd0);
                checkOutput("busy_calc", 32'(busy), 32'd1);
            end
            if (prev_hold) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    checkOutput("hold_data", 32'(out_data), 32'(held_data));
                    checkOutput("hold_last", 32'(out_last), 32'(held_last));
                end
            end
            if (out_valid) begin
                checkOutput("in_ready_drain", 32'(in_ready), 32'd0);
                if (!prev_valid && word_idx == 0) begin
                    if (lat_edge_q.size() == 0) begin
                        checkOutput("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = lat_edge_q.pop_front();
                        n = lat_n_q.pop_front();
                        checkOutput("first_valid_latency", 32'(ecount - e), 32'(n));
                    end
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        x = exp_q.pop_front();
                        checkOutput("out_data", 32'(out_data), 32'(x.data));
                        checkOutput("out_last", 32'(out_last), 32'(x.last));
                    end
                    word_idx  = (word_idx + 1) % 4;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end else begin
                prev_hold = 1'b0;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        frame_t m;
        frame_t base;
        bit     op;
        base = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        stall_mode = 0; gap_pct = 0;
        applyStimulus(1'b1, base, 8);
        waitDrain();
        applyStimulus(1'b0, base, 8);
        waitDrain();

        m = '{default: 8'hFF};
        applyStimulus(1'b1, m, 8);
        waitDrain();

        stall_mode = 2; gap_pct = 30;
        applyStimulus(1'b1, base, 8);
        waitDrain();

        // Abort a frame after five bytes, then load a clean frame of twos.
        stall_mode = 0; gap_pct = 0;
        applyStimulus(1'b1, base, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        m = '{default: 8'd2};
        applyStimulus(1'b0, m, 8);
        waitDrain();

        applyStimulus(1'b1, base, 8);
        applyStimulus(1'b0, base, 8);
        waitDrain();

        for (int f = 0; f < 24; f++) begin
            op = 1'($urandom);
            for (int i = 0; i < 8; i++) m[i] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            stall_mode = $urandom_range(2);
            gap_pct    = $urandom_range(40);
            applyStimulus(op, m, 8);
        end
        waitDrain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
